// File: rtl/riscv_mem_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, the core memsize
// encoding and the latched memory command.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } arb_state_e;

    // Core load/store size encoding (funct3 style).
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  size;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_wdog.sv
// Transfer watchdog: counts BUSY cycles since the last clear and flags the
// cycle that is the TIMEOUT-th one without an acknowledge.
module mem_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // cnt_q holds completed BUSY cycles, so the current cycle number is cnt_q + 1.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// one transfer in flight, with alternating tie-break and a watchdog abort.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [2:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    arb_state_e  state_q, state_d;
    logic        last_dm_q, last_dm_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        dm_ready_q, dm_ready_d;
    logic        bus_err_q, bus_err_d;

    logic        wdog_clear;
    logic        wdog_expired;
    logic        if_eligible;
    logic        dm_eligible;

    // A requester is still holding req during its own ready cycle; that is not a new request.
    assign if_eligible = if_req && !if_ready_q;
    assign dm_eligible = dm_req && !dm_ready_q;

    mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdog_clear),
        .enable  (mem_req),
        .expired (wdog_expired)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        last_dm_d  = last_dm_q;
        cmd_d      = cmd_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        bus_err_d  = 1'b0;
        wdog_clear = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dm_eligible && !(if_eligible && last_dm_q)) begin
                    state_d    = ST_BUSY_DM;
                    last_dm_d  = 1'b1;
                    cmd_d      = '{addr: dm_addr, we: dm_we, size: dm_size, wdata: dm_wdata};
                    wdog_clear = 1'b1;
                end else if (if_eligible) begin
                    state_d    = ST_BUSY_IF;
                    last_dm_d  = 1'b0;
                    cmd_d      = '{addr: if_addr, we: 1'b0, size: MEM_W, wdata: 32'd0};
                    wdog_clear = 1'b1;
                end
            end
            ST_BUSY_IF: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    if_ready_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end else if (wdog_expired) begin
                    state_d    = ST_IDLE;
                    if_ready_d = 1'b1;
                    bus_err_d  = 1'b1;
                end
            end
            ST_BUSY_DM: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    dm_ready_d = 1'b1;
                    if (!cmd_q.we) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else if (wdog_expired) begin
                    state_d    = ST_IDLE;
                    dm_ready_d = 1'b1;
                    bus_err_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            last_dm_q  <= 1'b0;
            cmd_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dm_q  <= last_dm_d;
            cmd_q      <= cmd_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign mem_req   = (state_q != ST_IDLE);
    assign mem_we    = cmd_q.we;
    assign mem_size  = cmd_q.size;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign bus_err   = bus_err_q;

endmodule
